// File: rtl/iconn_pkg.sv
// Shared types and constants for the 2x2 interconnect switch node.
package iconn_pkg;

  localparam int NODE_ADDR_WIDTH = 5;
  localparam int DATA_WIDTH      = 64;
  localparam int IN_PORTS        = 2;
  localparam int OUT_PORTS       = 2;

  typedef struct packed {
    logic [NODE_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]      data;
  } iconn_flit_t;

endpackage

// File: rtl/iconn_flit_fifo.sv
// Synchronous flit FIFO with occupancy count; DEPTH must be a power of 2.
module iconn_flit_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/iconn_switch_arb.sv
// Buffered 2x2 omega/butterfly switch node: per-input FIFOs, round-robin output
// arbitration, registered valid/ready on both sides, saturating conflict counter.
module iconn_switch_arb #(
  parameter int NODE_ADDR_WIDTH = iconn_pkg::NODE_ADDR_WIDTH,
  parameter int DATA_WIDTH      = iconn_pkg::DATA_WIDTH,
  parameter int ADDR_BIT_ID     = 0,
  parameter int FIFO_DEPTH      = 4,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NODE_ADDR_WIDTH-1:0] in_addr   [iconn_pkg::IN_PORTS],
  input  logic [DATA_WIDTH-1:0]      in_data   [iconn_pkg::IN_PORTS],
  input  logic [1:0]                 in_valid,
  output logic [1:0]                 in_ready,
  output logic [NODE_ADDR_WIDTH-1:0] out_addr  [iconn_pkg::OUT_PORTS],
  output logic [DATA_WIDTH-1:0]      out_data  [iconn_pkg::OUT_PORTS],
  output logic [1:0]                 out_valid,
  input  logic [1:0]                 out_ready,
  output logic [CNT_WIDTH-1:0]       conflict_cnt
);

  import iconn_pkg::*;

  localparam int FW    = NODE_ADDR_WIDTH + DATA_WIDTH;
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [OCC_W-1:0] DEPTH_V = OCC_W'(FIFO_DEPTH);

  logic [FW-1:0]    head     [IN_PORTS];
  logic [FW-1:0]    out_flit [OUT_PORTS];
  logic [OCC_W-1:0] occ      [IN_PORTS];
  logic [1:0]       full;
  logic [1:0]       empty;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       tgt;
  logic [1:0]       out_free;
  logic [1:0]       grant;
  logic [1:0]       sel;
  logic [1:0]       rr_ptr;
  logic [1:0]       rr_next;
  logic             conflict;

  for (genvar i = 0; i < IN_PORTS; i++) begin : g_in
    assign push[i] = in_valid[i] && in_ready[i] && !full[i];
    assign tgt[i]  = head[i][DATA_WIDTH + ADDR_BIT_ID];

    iconn_flit_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[i]),
      .wdata ({in_addr[i], in_data[i]}),
      .pop   (pop[i]),
      .rdata (head[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .count (occ[i])
    );
  end

  for (genvar j = 0; j < OUT_PORTS; j++) begin : g_out
    assign out_free[j] = !out_valid[j] || out_ready[j];
    assign out_addr[j] = out_flit[j][FW-1 -: NODE_ADDR_WIDTH];
    assign out_data[j] = out_flit[j][DATA_WIDTH-1:0];
  end

  assign conflict = !empty[0] && !empty[1] && (tgt[0] == tgt[1]);

  // NOTE: every signal driven here gets a default first so no path through the block infers a latch.
  always_comb begin
    pop     = '0;
    grant   = '0;
    sel     = '0;
    rr_next = rr_ptr;
    for (int j = 0; j < OUT_PORTS; j++) begin
      logic req0, req1;
      req0 = !empty[0] && (tgt[0] == 1'(j));
      req1 = !empty[1] && (tgt[1] == 1'(j));
      if (out_free[j] && (req0 || req1)) begin
        grant[j] = 1'b1;
        if (req0 && req1) begin
          sel[j]     = rr_ptr[j];
          rr_next[j] = ~rr_ptr[j];
        end else begin
          sel[j] = req1;
        end
        pop[sel[j]] = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready     <= '0;
      out_valid    <= '0;
      rr_ptr       <= '0;
      conflict_cnt <= '0;
      for (int j = 0; j < OUT_PORTS; j++) out_flit[j] <= '0;
    end else begin
      rr_ptr <= rr_next;
      if (conflict && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + 1'b1;
      for (int i = 0; i < IN_PORTS; i++) begin
        // Registered ready: look ahead at the occupancy this edge will leave behind.
        in_ready[i] <= (occ[i] + {{(OCC_W-1){1'b0}}, push[i]}
                               - {{(OCC_W-1){1'b0}}, pop[i]}) < DEPTH_V;
      end
      for (int j = 0; j < OUT_PORTS; j++) begin
        if (grant[j]) begin
          out_valid[j] <= 1'b1;
          out_flit[j]  <= head[sel[j]];
        end else if (out_ready[j]) begin
          out_valid[j] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_iconn_switch_arb.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_iconn_switch_arb;
  import iconn_pkg::*;

  localparam int AW    = NODE_ADDR_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int BIT   = 0;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] in_addr  [2];
  logic [DW-1:0] in_data  [2];
  logic [1:0]    in_valid;
  logic [1:0]    in_ready;
  logic [AW-1:0] out_addr [2];
  logic [DW-1:0] out_data [2];
  logic [1:0]    out_valid;
  logic [1:0]    out_ready;
  logic [CW-1:0] conflict_cnt;

  int checks   = 0;
  int failures = 0;

  iconn_switch_arb #(
    .NODE_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_BIT_ID(BIT),
    .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_addr(in_addr), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_addr(out_addr), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: queues of flits, one output slot per port, per-output favoured input.
  iconn_flit_t q [2][$];
  iconn_flit_t m_out    [2];
  bit          m_ov     [2];
  bit          m_rdy    [2];
  int          m_rr     [2];
  int          m_cnt;
  bit          m_pushed [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      q[i].delete();
      m_out[i]    = '0;
      m_ov[i]     = 1'b0;
      m_rdy[i]    = 1'b0;
      m_rr[i]     = 0;
      m_pushed[i] = 1'b0;
    end
    m_cnt = 0;
  endtask

  task automatic model_step();
    bit push [2];
    int tgt  [2];
    int win  [2];
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      push[i] = in_valid[i] && m_rdy[i];
      tgt[i]  = (q[i].size() > 0) ? int'(q[i][0].addr[BIT]) : -1;
    end
    if (tgt[0] >= 0 && tgt[0] == tgt[1] && m_cnt < CMAX) m_cnt++;
    for (int j = 0; j < 2; j++) begin
      win[j] = -1;
      if (!m_ov[j] || out_ready[j]) begin
        if (tgt[0] == j && tgt[1] == j) begin
          win[j]  = m_rr[j];
          m_rr[j] = 1 - win[j];
        end else if (tgt[0] == j) win[j] = 0;
        else if (tgt[1] == j)     win[j] = 1;
      end
      if (win[j] >= 0) begin
        m_out[j] = q[win[j]][0];
        m_ov[j]  = 1'b1;
      end else if (out_ready[j]) begin
        m_ov[j] = 1'b0;
      end
    end
    for (int j = 0; j < 2; j++) if (win[j] >= 0) void'(q[win[j]].pop_front());
    for (int i = 0; i < 2; i++) begin
      if (push[i]) q[i].push_back('{addr: in_addr[i], data: in_data[i]});
      m_pushed[i] = push[i];
      m_rdy[i]    = q[i].size() < DEPTH;
    end
  endtask

  task automatic compare();
    check("in_ready", 64'(in_ready), 64'({m_rdy[1], m_rdy[0]}));
    check("out_valid", 64'(out_valid), 64'({m_ov[1], m_ov[0]}));
    check("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
    for (int j = 0; j < 2; j++) begin
      check($sformatf("out_addr%0d", j), 64'(out_addr[j]), 64'(m_out[j].addr));
      check($sformatf("out_data%0d", j), out_data[j], m_out[j].data);
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic offer(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    in_addr[i]  = a;
    in_data[i]  = d;
    in_valid[i] = 1'b1;
  endtask

  task automatic async_reset_check(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_cnt"}, 64'(conflict_cnt), 64'd0);
    compare();
    @(negedge clk);
  endtask

  logic [DW-1:0] bp_seen [$];
  int            bp_k;

  initial begin
    model_reset();
    in_valid  = 2'b11;
    out_ready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      in_addr[i] = '0;
      in_data[i] = '0;
    end

    // Reset held with inputs offered
    @(negedge clk);
    compare();
    step();
    step();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_cnt", 64'(conflict_cnt), 64'd0);
    in_valid = 2'b00;
    rst_n = 1'b1;
    step();
    check("rel_in_ready", 64'(in_ready), 64'd3);

    // Straight pass
    offer(0, 5'b00000, 64'hAAAA_0000);
    offer(1, 5'b00001, 64'hBBBB_1111);
    step();
    in_valid = 2'b00;
    check("straight_early", 64'(out_valid), 64'd0);
    step();
    check("straight_valid", 64'(out_valid), 64'd3);
    check("straight_out0", out_data[0], 64'hAAAA_0000);
    check("straight_out1", out_data[1], 64'hBBBB_1111);
    step();

    // Cross
    offer(0, 5'b10101, 64'h0000_00A1);
    offer(1, 5'b10100, 64'h0000_00B1);
    step();
    in_valid = 2'b00;
    step();
    check("cross_valid", 64'(out_valid), 64'd3);
    check("cross_out1", out_data[1], 64'h0000_00A1);
    check("cross_out0", out_data[0], 64'h0000_00B1);
    check("cross_cnt", 64'(conflict_cnt), 64'd0);
    step();

    // Conflict, then a second contest favouring input 1
    offer(0, 5'b00010, 64'hC0C0_000A);
    offer(1, 5'b00100, 64'hC1C1_000B);
    step();
    in_valid = 2'b00;
    step();
    check("conf_first", out_data[0], 64'hC0C0_000A);
    check("conf_cnt", 64'(conflict_cnt), 64'd1);
    step();
    check("conf_second", out_data[0], 64'hC1C1_000B);
    offer(0, 5'b00110, 64'hD0D0_0002);
    offer(1, 5'b01000, 64'hD1D1_0002);
    step();
    in_valid = 2'b00;
    step();
    check("conf2_first", out_data[0], 64'hD1D1_0002);
    check("conf2_cnt", 64'(conflict_cnt), 64'd2);
    step();
    check("conf2_second", out_data[0], 64'hD0D0_0002);
    step();
    step();

    // Backpressure on out0: six flits from in0
    out_ready = 2'b10;
    bp_k = 0;
    offer(0, 5'b00000, 64'hBEEF_0000);
    for (int c = 0; c < 10; c++) begin
      step();
      if (m_pushed[0]) begin
        bp_k++;
        if (bp_k < 6) offer(0, 5'b00000, 64'hBEEF_0000 + 64'(bp_k));
        else in_valid[0] = 1'b0;
      end
    end
    check("bp_in_ready0", 64'(in_ready[0]), 64'd0);
    check("bp_hold", out_data[0], 64'hBEEF_0000);
    out_ready = 2'b11;
    for (int c = 0; c < 14; c++) begin
      if (out_valid[0] && out_ready[0]) bp_seen.push_back(out_data[0]);
      step();
      if (m_pushed[0]) begin
        bp_k++;
        if (bp_k < 6) offer(0, 5'b00000, 64'hBEEF_0000 + 64'(bp_k));
        else in_valid[0] = 1'b0;
      end
    end
    check("bp_count", 64'(bp_seen.size()), 64'd6);
    for (int k = 0; k < bp_seen.size(); k++)
      check($sformatf("bp_order%0d", k), bp_seen[k], 64'hBEEF_0000 + 64'(k));

    // Counter saturation, then reset mid-traffic
    offer(0, 5'b00000, 64'h5A5A_0000);
    offer(1, 5'b00010, 64'h5A5A_0001);
    for (int c = 0; c < 25; c++) step();
    check("sat_cnt", 64'(conflict_cnt), 64'(CMAX));
    async_reset_check("midrst");
    step();
    in_valid = 2'b00;
    rst_n = 1'b1;
    step();

    // Randomized traffic with a reset in the middle
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) begin
        async_reset_check("rndrst");
        step();
        rst_n = 1'b1;
      end
      for (int i = 0; i < 2; i++) begin
        if (!in_valid[i] || m_pushed[i]) begin
          in_valid[i] = ($urandom_range(0, 99) < 65);
          in_addr[i]  = AW'($urandom);
          in_data[i]  = {$urandom, $urandom};
        end
      end
      out_ready = {($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 70)};
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
